// File: rtl/div_seq_pkg.sv
// Shared types and default sizing for the iterative divider sequencer.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ZERO,
        DIV_ON,
        DIV_END
    } div_state_t;

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake bundle: request, operands, result and stall request.
interface div_seq_if
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic               start_i;
    logic               signed_i;
    logic               annul_i;
    logic [WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]   divisor_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               stallreq_o;

    modport master (
        output start_i,
        output signed_i,
        output annul_i,
        output dividend_i,
        output divisor_i,
        input  result_o,
        input  ready_o,
        input  stallreq_o
    );

    modport slave (
        input  start_i,
        input  signed_i,
        input  annul_i,
        input  dividend_i,
        input  divisor_i,
        output result_o,
        output ready_o,
        output stallreq_o
    );

endinterface

// File: rtl/div_seq_step.sv
// One combinational restoring-division step: shift {rem, dvd} left, trial subtract,
// and shift the new quotient bit into the low end of the dividend register.
module div_seq_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_dvd,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_dvd
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // The extra top bit of the trial difference is the borrow: set means the divisor did not fit.
    always_comb begin
        w_shifted = {i_rem, i_dvd[WIDTH-1]};
        w_trial   = w_shifted - {1'b0, i_dvs};
        if (!w_trial[WIDTH]) begin
            o_rem = w_trial[WIDTH-1:0];
            o_dvd = {i_dvd[WIDTH-2:0], 1'b1};
        end else begin
            o_rem = w_shifted[WIDTH-1:0];
            o_dvd = {i_dvd[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in EX; holds the stall request
// until {remainder, quotient} is ready for the HI/LO write.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic     clk,
    input  logic     rst,
    div_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    div_state_t         r_state;
    div_state_t         w_nextState;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_negQuot;
    logic               r_negRem;
    logic [2*WIDTH-1:0] r_result;

    logic [WIDTH-1:0]   w_remStep;
    logic [WIDTH-1:0]   w_dvdStep;
    logic [WIDTH-1:0]   w_dvdAbs;
    logic [WIDTH-1:0]   w_dvsAbs;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;
    logic               w_accept;
    logic               w_ready;

    div_seq_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_dvd (r_dvd),
        .i_dvs (r_dvs),
        .o_rem (w_remStep),
        .o_dvd (w_dvdStep)
    );

    // Magnitudes are taken only for DIV; the most negative value maps onto itself, which is
    // exactly its magnitude when read as unsigned.
    always_comb begin
        w_accept  = bus.start_i & ~bus.annul_i;
        w_dvdAbs  = (bus.signed_i & bus.dividend_i[WIDTH-1]) ? -bus.dividend_i : bus.dividend_i;
        w_dvsAbs  = (bus.signed_i & bus.divisor_i[WIDTH-1])  ? -bus.divisor_i  : bus.divisor_i;
        w_quotFix = r_negQuot ? -r_dvd : r_dvd;
        w_remFix  = r_negRem  ? -r_rem : r_rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            DIV_IDLE: begin
                if (w_accept) begin
                    w_nextState = (bus.divisor_i == '0) ? DIV_ZERO : DIV_ON;
                end
            end
            DIV_ZERO: begin
                w_nextState = bus.annul_i ? DIV_IDLE : DIV_END;
            end
            DIV_ON: begin
                if (bus.annul_i) begin
                    w_nextState = DIV_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_nextState = DIV_END;
                end
            end
            DIV_END: begin
                if (!bus.start_i || bus.annul_i) begin
                    w_nextState = DIV_IDLE;
                end
            end
            default: begin
                w_nextState = DIV_IDLE;
            end
        endcase
    end

    // Stall is released combinationally in the first END cycle so EX can retire the same cycle.
    always_comb begin
        w_ready        = (r_state == DIV_END);
        bus.ready_o    = w_ready;
        bus.result_o   = w_ready ? r_result : '0;
        bus.stallreq_o = bus.start_i & ~w_ready & ~bus.annul_i;
    end

    // Operands are captured once at acceptance; later changes on the inputs are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_negQuot <= 1'b0;
            r_negRem  <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept && (bus.divisor_i != '0)) begin
                        r_dvd     <= w_dvdAbs;
                        r_dvs     <= w_dvsAbs;
                        r_negQuot <= bus.signed_i & (bus.dividend_i[WIDTH-1] ^ bus.divisor_i[WIDTH-1]);
                        r_negRem  <= bus.signed_i & bus.dividend_i[WIDTH-1];
                        r_cnt     <= '0;
                        r_rem     <= '0;
                    end
                end
                DIV_ZERO: begin
                    if (!bus.annul_i) begin
                        r_result <= '0;
                    end
                end
                DIV_ON: begin
                    if (!bus.annul_i) begin
                        if (r_cnt != LAST_CNT) begin
                            r_rem <= w_remStep;
                            r_dvd <= w_dvdStep;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            r_result <= {w_remFix, w_quotFix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: cycle-level behavioural model plus directed
// literal cases and randomized divides with annuls and operand scrambling.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic        checkEn = 1'b0;

    logic        mBusy   = 1'b0;
    logic        mDone   = 1'b0;
    int          mRemain = 0;
    logic [63:0] mResult = 64'd0;

    function automatic logic [63:0] refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            4:       return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        nChecks++;
        if (got !== want) begin
            nFails++;
            $display("[TB] FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Model in terms of request/latency only: a divide is pending for a fixed number of
    // cycles after acceptance, then the result is held while start stays high.
    always @(posedge clk) begin
        if (rst) begin
            mBusy   <= 1'b0;
            mDone   <= 1'b0;
            mRemain <= 0;
        end else if (mDone) begin
            if (!bus.start_i || bus.annul_i) mDone <= 1'b0;
        end else if (mBusy) begin
            if (bus.annul_i) begin
                mBusy <= 1'b0;
            end else if (mRemain == 1) begin
                mBusy <= 1'b0;
                mDone <= 1'b1;
            end else begin
                mRemain <= mRemain - 1;
            end
        end else if (bus.start_i && !bus.annul_i) begin
            mBusy   <= 1'b1;
            mRemain <= (bus.divisor_i == 32'd0) ? 1 : 33;
            mResult <= refDiv(bus.signed_i, bus.dividend_i, bus.divisor_i);
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cyc_ready", {63'd0, bus.ready_o}, {63'd0, mDone});
            checkOutput("cyc_result", bus.result_o, mDone ? mResult : 64'd0);
            checkOutput("cyc_stallreq", {63'd0, bus.stallreq_o},
                        {63'd0, bus.start_i & ~mDone & ~bus.annul_i});
        end
    end

    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                 input int annulAt, input logic scramble,
                                 output int lat, output int stalls, output logic gotReady,
                                 output logic [63:0] res);
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        bus.annul_i    = 1'b0;
        lat      = 0;
        stalls   = 0;
        gotReady = 1'b0;
        res      = 64'd0;
        for (int c = 0; c < 60; c++) begin
            if (c == annulAt) bus.annul_i = 1'b1;
            @(negedge clk);
            if (bus.ready_o) begin
                gotReady = 1'b1;
                res      = bus.result_o;
                break;
            end
            if (bus.stallreq_o) stalls++;
            if (c == annulAt) break;
            @(posedge clk);
            #1;
            lat++;
            if (scramble) begin
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
                bus.signed_i   = 1'($urandom_range(0, 1));
            end
        end
        if (!gotReady && annulAt < 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL timeout: ready_o not seen after %0d cycles, required within 34", lat);
        end
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          stalls;
        logic        gotReady;
        logic [63:0] res;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          annulAt;

        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.annul_i    = 1'b0;
        bus.dividend_i = 32'd0;
        bus.divisor_i  = 32'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("reset_result", bus.result_o, 64'd0);
        checkOutput("reset_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk);
        #1;

        applyStimulus(1'b0, 32'd100, 32'd7, -1, 1'b1, lat, stalls, gotReady, res);
        checkOutput("divu_100_7_result", res, 64'h0000_0002_0000_000E);
        checkOutput("divu_100_7_latency", 64'(lat), 64'd34);
        checkOutput("divu_100_7_stalls", 64'(stalls), 64'd34);

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 1'b0, lat, stalls, gotReady, res);
        checkOutput("div_m7_2_result", res, 64'hFFFF_FFFF_FFFF_FFFD);

        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0, lat, stalls, gotReady, res);
        checkOutput("div_min_m1_result", res, 64'h0000_0000_8000_0000);

        applyStimulus(1'b0, 32'd5, 32'd0, -1, 1'b0, lat, stalls, gotReady, res);
        checkOutput("divu_5_0_result", res, 64'd0);
        checkOutput("divu_5_0_latency", 64'(lat), 64'd2);
        checkOutput("divu_5_0_stalls", 64'(stalls), 64'd2);

        applyStimulus(1'b0, 32'd1000, 32'd3, 10, 1'b0, lat, stalls, gotReady, res);
        checkOutput("annul_no_ready", {63'd0, gotReady}, 64'd0);
        checkOutput("annul_stalls", 64'(stalls), 64'd10);
        repeat (3) begin
            @(negedge clk);
            checkOutput("annul_ready_low", {63'd0, bus.ready_o}, 64'd0);
        end
        @(posedge clk);
        #1;

        bus.start_i    = 1'b1;
        bus.signed_i   = 1'b0;
        bus.dividend_i = 32'd1000;
        bus.divisor_i  = 32'd3;
        repeat (20) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_ready", {63'd0, bus.ready_o}, 64'd0);
        checkOutput("midrst_result", bus.result_o, 64'd0);
        checkOutput("midrst_stallreq", {63'd0, bus.stallreq_o}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'd9, 32'd3, -1, 1'b0, lat, stalls, gotReady, res);
        checkOutput("divu_9_3_result", res, 64'h0000_0000_0000_0003);

        for (int i = 0; i < 30; i++) begin
            sgn     = 1'($urandom_range(0, 1));
            a       = pickOperand();
            b       = pickOperand();
            annulAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 36)) : -1;
            applyStimulus(sgn, a, b, annulAt, 1'b1, lat, stalls, gotReady, res);
            if (gotReady) begin
                checkOutput("rand_result", res, refDiv(sgn, a, b));
                checkOutput("rand_latency", 64'(lat), (b == 32'd0) ? 64'd2 : 64'd34);
            end
        end

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
